// File: rtl/stack_cpu_gen2_pkg.sv
// rtl/stack_cpu_gen2_pkg.sv - opcodes, FSM states, error codes and default widths for stack_cpu_gen2
package stack_cpu_gen2_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_STACK_DEPTH = 16;
  localparam int DEF_INSTR_WIDTH = 16;
  localparam int DEF_PC_WIDTH    = 8;

  typedef enum logic [4:0] {
    OP_PUSHI = 5'd1,  OP_ADD  = 5'd2,  OP_SUB  = 5'd3,  OP_MUL  = 5'd4,
    OP_DIV   = 5'd5,  OP_MOD  = 5'd6,  OP_AND  = 5'd7,  OP_OR   = 5'd8,
    OP_INV   = 5'd9,  OP_DUP  = 5'd10, OP_SWAP = 5'd11, OP_DROP = 5'd12,
    OP_JMP   = 5'd13, OP_JZ   = 5'd14, OP_HALT = 5'd15
  } opcode_t;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH  = 3'd0;
  localparam state_t S_DECODE = 3'd1;
  localparam state_t S_POP2   = 3'd2;
  localparam state_t S_POP1   = 3'd3;
  localparam state_t S_EXEC   = 3'd4;
  localparam state_t S_PUSH   = 3'd5;
  localparam state_t S_HALTED = 3'd6;
  localparam state_t S_ERROR  = 3'd7;

  typedef enum logic [2:0] {
    ERR_NONE = 3'd0, ERR_OVERFLOW = 3'd1, ERR_UNDERFLOW = 3'd2,
    ERR_DIV_ZERO = 3'd3, ERR_ILLEGAL = 3'd4
  } err_code_t;

  function automatic logic is_legal(input logic [4:0] op);
    return (op >= 5'd1) && (op <= 5'd15);
  endfunction

  function automatic logic needs_two_pops(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_OR)) || (op == OP_SWAP);
  endfunction

  function automatic logic needs_one_pop(input logic [4:0] op);
    return (op == OP_INV) || (op == OP_DROP) || (op == OP_JZ);
  endfunction

endpackage

// File: rtl/stack_cpu_gen2_lifo.sv
// rtl/stack_cpu_gen2_lifo.sv - stack_lifo: register-file LIFO with full/empty flags
module stack_lifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         sp;
  logic [AW-1:0]         wr_idx;
  logic [AW-1:0]         rd_idx;

  assign wr_idx   = AW'(sp);
  assign rd_idx   = AW'(sp - PW'(1));
  assign data_out = mem[rd_idx];
  assign full     = (sp == PW'(DEPTH));
  assign empty    = (sp == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PW'(1);
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= data_in;
    end
  end

endmodule

// File: rtl/stack_cpu_gen2.sv
// rtl/stack_cpu_gen2.sv - multi-cycle stack CPU top; STACK_CPU_SSTEP_EN gates FETCH on single_step rising edges
module stack_cpu_gen2
  import stack_cpu_gen2_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int PC_WIDTH    = DEF_PC_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INSTR_WIDTH-1:0]       instruction,
  input  logic                         single_step,
  output logic [PC_WIDTH-1:0]          pc,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         valid_result,
  output logic                         error,
  output logic [2:0]                   error_code,
  output logic                         halt
);
  localparam int IMM_W = INSTR_WIDTH - 6;

  state_t                       state;
  logic [INSTR_WIDTH-1:0]       ir;
  logic signed [DATA_WIDTH-1:0] op1, op2, alu, imm_ext;
  logic [DATA_WIDTH-1:0]        w0, w1, top;
  logic                         second_pending;
  logic [4:0]                   op;
  logic signed [IMM_W-1:0]      imm;
  logic [PC_WIDTH-1:0]          target, pc_next;
  logic                         lifo_push, lifo_pop, full, empty, step_go;

  assign op      = ir[INSTR_WIDTH-1 -: 5];
  assign imm     = ir[IMM_W-1:0];
  assign imm_ext = DATA_WIDTH'(imm);
  assign target  = PC_WIDTH'(ir[IMM_W-1:0]);
  assign pc_next = pc + PC_WIDTH'(1);

`ifdef STACK_CPU_SSTEP_EN
  logic step_prev;
  logic unused_bits;
  assign unused_bits = ir[INSTR_WIDTH-6];
  assign step_go     = single_step && !step_prev;
  always_ff @(posedge clk) begin
    if (reset) step_prev <= 1'b0;
    else       step_prev <= single_step;
  end
`else
  logic unused_bits;
  assign unused_bits = ir[INSTR_WIDTH-6] ^ single_step;
  assign step_go     = 1'b1;
`endif

  stack_lifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(STACK_DEPTH)) u_lifo (
    .clk(clk), .reset(reset), .push(lifo_push), .pop(lifo_pop),
    .data_in(w0), .data_out(top), .full(full), .empty(empty)
  );

  // DUP consumes the top in EXEC and re-pushes it twice, so the net effect is +1.
  always_comb begin
    lifo_push = 1'b0;
    lifo_pop  = 1'b0;
    case (state)
      S_POP2, S_POP1: lifo_pop  = !empty;
      S_EXEC:         lifo_pop  = (op == OP_DUP) && !empty;
      S_PUSH:         lifo_push = !full;
      default: ;
    endcase
  end

  always_comb begin
    alu = '0;
    case (op)
      OP_PUSHI: alu = imm_ext;
      OP_ADD:   alu = op1 + op2;
      OP_SUB:   alu = op1 - op2;
      OP_MUL:   alu = op1 * op2;
      OP_DIV:   alu = (op2 != '0) ? op1 / op2 : '0;
      OP_MOD:   alu = (op2 != '0) ? op1 % op2 : '0;
      OP_AND:   alu = op1 & op2;
      OP_OR:    alu = op1 | op2;
      OP_INV:   alu = ~op1;
      default:  alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_FETCH;
      pc             <= '0;
      ir             <= '0;
      op1            <= '0;
      op2            <= '0;
      w0             <= '0;
      w1             <= '0;
      second_pending <= 1'b0;
      result         <= '0;
      valid_result   <= 1'b0;
      error          <= 1'b0;
      error_code     <= ERR_NONE;
      halt           <= 1'b0;
    end else begin
      valid_result <= 1'b0;
      case (state)
        S_FETCH: if (step_go) begin
          ir    <= instruction;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (!is_legal(op)) begin
            error <= 1'b1; error_code <= ERR_ILLEGAL; state <= S_ERROR;
          end else if (op == OP_HALT) begin
            pc <= pc_next; halt <= 1'b1; state <= S_HALTED;
          end else if (needs_two_pops(op)) state <= S_POP2;
          else if (needs_one_pop(op))      state <= S_POP1;
          else                             state <= S_EXEC;
        end
        S_POP2, S_POP1: begin
          if (empty) begin
            error <= 1'b1; error_code <= ERR_UNDERFLOW; state <= S_ERROR;
          end else if (state == S_POP2) begin
            op2 <= top; state <= S_POP1;
          end else begin
            op1 <= top; state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if ((op == OP_DIV || op == OP_MOD) && op2 == '0) begin
            error <= 1'b1; error_code <= ERR_DIV_ZERO; state <= S_ERROR;
          end else if (op == OP_DUP && empty) begin
            error <= 1'b1; error_code <= ERR_UNDERFLOW; state <= S_ERROR;
          end else begin
            case (op)
              OP_JMP:  begin pc <= target; state <= S_FETCH; end
              OP_JZ:   begin pc <= (op1 == '0) ? target : pc_next; state <= S_FETCH; end
              OP_DROP: begin pc <= pc_next; state <= S_FETCH; end
              OP_DUP:  begin w0 <= top; w1 <= top; second_pending <= 1'b1; state <= S_PUSH; end
              OP_SWAP: begin w0 <= op2; w1 <= op1; second_pending <= 1'b1; state <= S_PUSH; end
              default: begin w0 <= alu; second_pending <= 1'b0; state <= S_PUSH; end
            endcase
          end
        end
        S_PUSH: begin
          if (full) begin
            error <= 1'b1; error_code <= ERR_OVERFLOW; state <= S_ERROR;
          end else begin
            result       <= w0;
            valid_result <= 1'b1;
            if (second_pending) begin
              w0 <= w1; second_pending <= 1'b0;
            end else begin
              pc <= pc_next; state <= S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu_gen2.sv
// tb/tb_stack_cpu_gen2.sv - scoreboard bench for stack_cpu_gen2 with a queue-based reference model
module tb_stack_cpu_gen2;
  import stack_cpu_gen2_pkg::*;

  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               single_step = 1'b0;
  logic [15:0]        instruction;
  logic [7:0]         pc;
  logic signed [15:0] result;
  logic               valid_result, error, halt;
  logic [2:0]         error_code;

  logic [15:0] prog [256];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_strobe = 0;
  int          exp_q[$];
  int          exp_pc, exp_code, exp_depth;
  bit          exp_halt;
  bit          auto_step = 1'b1;

  always #5 clk = ~clk;
  assign instruction = prog[pc];

  stack_cpu_gen2 #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .single_step(single_step),
    .pc(pc), .result(result), .valid_result(valid_result), .error(error),
    .error_code(error_code), .halt(halt)
  );

  function automatic void check(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  always @(negedge clk) if (auto_step) single_step = ~single_step;

  always @(negedge clk) begin
    if (!reset && valid_result) begin
      n_strobe++;
      check("scoreboard has entry at push", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("pushed value", result, exp_q.pop_front());
    end
  end

  function automatic logic [15:0] enc(input int op, input int imm);
    return {op[4:0], 1'b0, imm[9:0]};
  endfunction

  function automatic int wrap16(input int x);
    int y;
    y = x & 32'hFFFF;
    return (y >= 32768) ? y - 65536 : y;
  endfunction

  function automatic int arith(input logic [4:0] op, input int a, input int b);
    case (op)
      OP_ADD:  return wrap16(a + b);
      OP_SUB:  return wrap16(a - b);
      OP_MUL:  return wrap16(a * b);
      OP_DIV:  return wrap16(a / b);
      OP_MOD:  return wrap16(a % b);
      OP_AND:  return wrap16(a & b);
      default: return wrap16(a | b);
    endcase
  endfunction

  // Instruction-level model: a bounded queue as the stack, pc advanced per instruction.
  task automatic model_run();
    int stk[$];
    int p = 0;
    int steps = 0;
    bit done = 0;
    exp_code = 0;
    exp_halt = 0;
    while (!done && steps < 1000) begin
      logic [15:0] ins;
      logic [4:0]  o;
      int imm, a, b, np, code;
      ins = prog[p];
      o = ins[15:11];
      imm = int'(ins[9:0]);
      if (imm >= 512) imm -= 1024;
      np = (p + 1) % 256;
      code = 0;
      steps++;
      case (o)
        OP_PUSHI: if (stk.size() == DEPTH) code = 1;
                  else begin stk.push_back(wrap16(imm)); exp_q.push_back(wrap16(imm)); end
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR, OP_SWAP: begin
          if (stk.size() < 2) begin stk.delete(); code = 2; end
          else begin
            b = stk.pop_back();
            a = stk.pop_back();
            if ((o == OP_DIV || o == OP_MOD) && b == 0) code = 3;
            else if (o == OP_SWAP) begin
              stk.push_back(b); exp_q.push_back(b);
              stk.push_back(a); exp_q.push_back(a);
            end else begin
              stk.push_back(arith(o, a, b)); exp_q.push_back(arith(o, a, b));
            end
          end
        end
        OP_INV, OP_DROP, OP_JZ: begin
          if (stk.size() == 0) code = 2;
          else begin
            a = stk.pop_back();
            if (o == OP_INV) begin stk.push_back(wrap16(~a)); exp_q.push_back(wrap16(~a)); end
            if (o == OP_JZ && a == 0) np = int'(ins[7:0]);
          end
        end
        OP_DUP: begin
          if (stk.size() == 0) code = 2;
          else begin
            a = stk.pop_back();
            stk.push_back(a); exp_q.push_back(a);
            if (stk.size() == DEPTH) code = 1;
            else begin stk.push_back(a); exp_q.push_back(a); end
          end
        end
        OP_JMP:  np = int'(ins[7:0]);
        OP_HALT: exp_halt = 1;
        default: code = 4;
      endcase
      if (code != 0) begin exp_code = code; done = 1; end
      else begin p = np; if (exp_halt) done = 1; end
    end
    exp_pc = p;
    exp_depth = stk.size();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = enc(OP_HALT, 0);
  endtask

  task automatic run_prog(input string nm);
    int n = 0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    n_strobe = 0;
    repeat (2) @(negedge clk);
    model_run();
    reset = 1'b0;
    while (!(halt || error) && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check({nm, " stopped"}, halt | error, 1);
    check({nm, " pc"}, pc, exp_pc);
    check({nm, " error"}, error, exp_code != 0);
    check({nm, " error_code"}, error_code, exp_code);
    check({nm, " halt"}, halt, exp_halt);
    check({nm, " depth"}, dut.u_lifo.sp, exp_depth);
    check({nm, " pending pushes"}, exp_q.size(), 0);
  endtask

  initial begin
    clear_prog();
    repeat (2) @(negedge clk);
    check("reset pc", pc, 0);
    check("reset result", result, 0);
    check("reset valid_result", valid_result, 0);
    check("reset error", error, 0);
    check("reset error_code", error_code, 0);
    check("reset halt", halt, 0);

    clear_prog();
    prog[0] = enc(OP_PUSHI, 7); prog[1] = enc(OP_PUSHI, 3); prog[2] = enc(OP_SUB, 0);
    run_prog("sub");
    check("sub result", result, 4);
    check("sub strobes", n_strobe, 3);
    check("sub halt pc", pc, 4);

    clear_prog();
    prog[0] = enc(OP_PUSHI, 5); prog[1] = enc(OP_PUSHI, 0); prog[2] = enc(OP_DIV, 0);
    run_prog("div0");
    repeat (10) @(negedge clk);
    check("div0 code", error_code, 3);
    check("div0 pc frozen", pc, 2);
    check("div0 depth", dut.u_lifo.sp, 0);

    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = enc(OP_PUSHI, 1);
    run_prog("overflow");
    check("overflow code", error_code, 1);

    clear_prog();
    prog[0] = enc(OP_DROP, 0);
    run_prog("underflow");
    check("underflow code", error_code, 2);

    clear_prog();
    prog[0] = enc(OP_PUSHI, 0); prog[1] = enc(OP_JZ, 10); prog[10] = enc(0, 0);
    run_prog("jz taken");
    check("jz taken pc", pc, 10);

    clear_prog();
    prog[0] = enc(OP_PUSHI, 1); prog[1] = enc(OP_JZ, 10); prog[2] = enc(0, 0);
    run_prog("jz not taken");
    check("jz not taken pc", pc, 2);

    clear_prog();
    prog[0] = enc(OP_PUSHI, 'h3FE);
    run_prog("pushi neg");
    check("pushi neg result", result, -2);

    clear_prog();
    prog[0] = enc(OP_PUSHI, 6); prog[1] = enc(OP_PUSHI, 9); prog[2] = enc(OP_SWAP, 0);
    prog[3] = enc(OP_DUP, 0); prog[4] = enc(OP_SUB, 0);
    run_prog("swap dup");

    for (int t = 0; t < 40; t++) begin
      int len;
      len = $urandom_range(6, 24);
      clear_prog();
      for (int i = 0; i < len - 1; i++) begin
        int r, op, imm;
        r = $urandom_range(0, 99);
        imm = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1023) : $urandom_range(0, 3);
        if (r < 35)      op = OP_PUSHI;
        else if (r < 38) op = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(16, 31);
        else             op = $urandom_range(2, 14);
        if (op == OP_JMP || op == OP_JZ) imm = $urandom_range(i + 1, len - 1);
        prog[i] = enc(op, imm);
      end
      run_prog($sformatf("rand%0d", t));
    end

`ifdef STACK_CPU_SSTEP_EN
    begin
      int n = 0;
      auto_step = 1'b0;
      single_step = 1'b0;
      clear_prog();
      prog[0] = enc(OP_PUSHI, 9); prog[1] = enc(OP_PUSHI, 5);
      @(negedge clk);
      reset = 1'b1; exp_q.delete(); n_strobe = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("sstep idle pc", pc, 0);
      check("sstep idle strobes", n_strobe, 0);
      exp_q.push_back(9);
      single_step = 1'b1;
      @(negedge clk);
      single_step = 1'b0;
      repeat (15) @(negedge clk);
      check("sstep one pc", pc, 1);
      check("sstep one strobes", n_strobe, 1);
      check("sstep one result", result, 9);
      single_step = 1'b1;
      while (dut.state != S_EXEC && n < 20) begin @(negedge clk); n++; end
      check("sstep reached exec", dut.state == S_EXEC, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid-exec reset pc", pc, 0);
      check("mid-exec reset result", result, 0);
      check("mid-exec reset valid", valid_result, 0);
      check("mid-exec reset error", error, 0);
      check("mid-exec reset code", error_code, 0);
      check("mid-exec reset halt", halt, 0);
      check("mid-exec reset depth", dut.u_lifo.sp, 0);
      single_step = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      auto_step = 1'b1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_cpu_gen2.md
STACK_CPU_GEN2 -- requirements
Module: stack_cpu_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, stack element and ALU width.
REQ-002 SHALL have parameter STACK_DEPTH, default 16, stack entries, minimum 2.
REQ-003 SHALL have parameter INSTR_WIDTH, default 16, instruction width, minimum 8.
REQ-004 SHALL have parameter PC_WIDTH, default 8, program counter width.
REQ-005 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port instruction  input  INSTR_WIDTH  {opcode[4:0], 1'b0, imm[INSTR_WIDTH-7:0]}, valid for the current pc.
REQ-008 SHALL have port single_step  input  1  step request; a rising edge releases one instruction.
REQ-009 SHALL have port pc  output  PC_WIDTH  program counter.
REQ-010 SHALL have port result  output  DATA_WIDTH signed  registered value last pushed.
REQ-011 SHALL have port valid_result  output  1  one-cycle strobe when result updates.
REQ-012 SHALL have port error  output  1  sticky error flag.
REQ-013 SHALL have port error_code  output  3  0 none, 1 overflow, 2 underflow, 3 divide-by-zero, 4 illegal opcode.
REQ-014 SHALL have port halt  output  1  sticky halted flag.

Function
REQ-015 SHALL support opcodes PUSHI, ADD, SUB, MUL, DIV, MOD, AND, OR, INV, DUP, SWAP, DROP, JMP, JZ and HALT; all other codes are illegal.
REQ-016 SHALL sign-extend imm to DATA_WIDTH for PUSHI; JMP/JZ use imm truncated/zero-extended to PC_WIDTH as target.
REQ-017 SHALL run FSM states FETCH, DECODE, POP2, POP1, EXEC, PUSH, HALTED, ERROR, one cycle each.
REQ-018 SHALL sequence: FETCH->DECODE; binary ops and SWAP: DECODE->POP2->POP1->EXEC->PUSH; INV, DROP, JZ: DECODE->POP1->EXEC; DUP, PUSHI, JMP: DECODE->EXEC; EXEC->PUSH when a push is needed, else FETCH; PUSH->FETCH.
REQ-019 SHALL take op1 as second-from-top and op2 as top; SUB=op1-op2, DIV/MOD signed, truncating toward zero; MUL keeps low DATA_WIDTH bits; all arithmetic wraps.
REQ-020 SHALL push two words for SWAP (old top first, then old second) and two for DUP, each in its own PUSH cycle.
REQ-021 SHALL increment pc on entry to FETCH except after JMP (pc<=target) or JZ with popped value 0 (pc<=target); pc wraps at 2**PC_WIDTH.
REQ-022 SHALL register result and assert valid_result for exactly the cycle after each push.
REQ-023 SHALL enter ERROR with code 1 on push when full, 2 on pop when empty, 3 on DIV/MOD with op2==0, 4 on illegal opcode; no stack write occurs that cycle.
REQ-024 SHALL enter HALTED on HALT opcode; HALTED and ERROR are absorbing, pc frozen, no push/pop.
REQ-025 SHALL, when error and halt conditions coincide, report error only.

Reset
REQ-026 SHALL on reset, regardless of state: pc=0, state=FETCH, stack empty, result=0, valid_result=0, error=0, error_code=0, halt=0.
REQ-027 SHALL abandon any in-flight instruction on reset with no partial stack update.

Configuration
REQ-028 SHALL compile single-stepping in with macro STACK_CPU_SSTEP_EN: FETCH stalls until a rising edge of single_step (registered previous value); reset clears the edge detector.
REQ-029 SHALL, without STACK_CPU_SSTEP_EN, ignore single_step and leave FETCH after one cycle.

Structure
REQ-030 SHALL place opcode_t, state_t, error code enum and default width constants in package stack_cpu_gen2_pkg.
REQ-031 SHALL instantiate one sub-module stack_lifo (parametrised DATA_WIDTH, DEPTH; push, pop, data_in, data_out, full, empty).

Verification
REQ-032 SHALL check: PUSHI 7, PUSHI 3, SUB, HALT -> result 4 with one valid_result strobe per push, halt=1, pc=4.
REQ-033 SHALL check: PUSHI 5, PUSHI 0, DIV -> error=1, error_code=3, pc frozen, stack depth 0.
REQ-034 SHALL check: STACK_DEPTH=4, five PUSHI 1 -> error_code=1 on fifth push; DROP on empty -> error_code=2.
REQ-035 SHALL check: PUSHI 0, JZ 10 -> pc=10; PUSHI 1, JZ 10 -> pc advances sequentially; PUSHI -2 (imm 0x3FE) -> result -2.
REQ-036 SHALL check with STACK_CPU_SSTEP_EN: single_step held low -> pc static; one low-high pulse -> exactly one instruction completes; reset asserted mid-EXEC -> all outputs at reset values next cycle.
